// File: rtl/uart_receiver.sv
// 8N1 UART receiver with a 2-flop line synchroniser, a mid-bit sampling FSM and a one-byte output holding register.
// Define UART_RX_MAJORITY_EN to take each sample as a 2-of-3 vote over the last three synchronised line values.
module uart_receiver #(
    parameter int unsigned CLKS_PER_BIT = 10416
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RxD,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);

    // state  | meaning
    // IDLE   | waiting for a falling edge on the synchronised line
    // START  | counting to mid start bit to confirm it is still low
    // DATA   | sampling eight data bits at one-bit intervals, LSB first
    // STOP   | sampling the stop bit; high completes the byte, low is a framing error

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [1:0]    sync_vld_q, sync_vld_d;
    logic          rxd_prev_q, rxd_prev_d;
    logic          rxd_s;
    logic          sample_bit;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          done_q, done_d;
    logic          ferr_q, ferr_d;

    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          ovr_q, ovr_d;

    assign rxd_s = sync2_q;

    // sync_vld marks when rxd_s reflects the real line rather than the reset
    // preset, so a line held low across reset is never mistaken for an edge.
    always_comb begin
        sync1_d    = RxD;
        sync2_d    = sync1_q;
        sync_vld_d = {sync_vld_q[0], 1'b1};
        rxd_prev_d = sync_vld_q[1] & rxd_s;
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q, hist_d;

    always_comb begin
        hist_d     = {hist_q[0], rxd_s};
        sample_bit = (rxd_s & hist_q[0]) | (rxd_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= hist_d;
        end
    end
`else
    always_comb begin
        sample_bit = rxd_s;
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rxd_prev_q && !rxd_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    state_d = sample_bit ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = sample_bit;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (sample_bit) begin
                        done_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A completed byte lands one edge after the stop sample; a held,
    // unaccepted byte wins over the new one.
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        ovr_d      = 1'b0;

        if (done_q) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            sync_vld_q <= 2'b00;
            rxd_prev_q <= 1'b0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= 3'd0;
            shift_q    <= 8'h00;
            done_q     <= 1'b0;
            ferr_q     <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            sync_vld_q <= sync_vld_d;
            rxd_prev_q <= rxd_prev_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            done_q     <= done_d;
            ferr_q     <= ferr_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            ovr_q      <= ovr_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign busy      = (state_q != IDLE);
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: the driver queues expected bytes, framing errors and overruns per frame,
// and a negedge monitor retires them as the receiver reports them, including the rx_valid latency.
module tb_uart_receiver;

    localparam int CPB = 16;
    localparam int HALF = CPB / 2;
    localparam int LAT = 2 + HALF + 9 * CPB + 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       RxD;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .reset     (reset),
        .RxD       (RxD),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         rise;
    } exp_t;

    exp_t exp_q[$];
    int   ferr_pend = 0;
    int   ovr_pend = 0;
    bit   model_held = 1'b0;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int rise_cyc = 0;
    logic last_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rx_valid && !last_valid) rise_cyc = cyc;
        last_valid = rx_valid;
        if (rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_byte: got %0h expected none", rx_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rx_data", rx_data, e.data);
                chk("rx_valid_latency", rise_cyc, e.rise);
            end
        end
        if (frame_err) begin
            tests++;
            if (ferr_pend == 0) begin
                fails++;
                $display("FAIL unexpected_frame_err: got 1 expected 0");
            end else ferr_pend--;
        end
        if (overrun) begin
            tests++;
            if (ovr_pend == 0) begin
                fails++;
                $display("FAIL unexpected_overrun: got 1 expected 0");
            end else ovr_pend--;
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // One data bit, optionally with a single-cycle low glitch on the sample point.
    task automatic drive_bit(input logic v, input bit glitch);
        @(posedge clk);
        #1 RxD = v;
        if (glitch) begin
            repeat (HALF) @(posedge clk);
            #1 RxD = 1'b0;
            @(posedge clk);
            #1 RxD = v;
            repeat (CPB - HALF - 2) @(posedge clk);
        end else begin
            repeat (CPB - 1) @(posedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int gap, input int glitch_bit);
        int   c0;
        int   g;
        exp_t e;
        @(posedge clk);
        #1;
        c0 = cyc + 1;
        if (!stop_bit) begin
            ferr_pend++;
        end else if (model_held) begin
            ovr_pend++;
        end else begin
            e.data = b;
            e.rise = c0 + LAT;
            exp_q.push_back(e);
            if (!rx_ready) model_held = 1'b1;
        end
        RxD = 1'b0;
        repeat (CPB - 1) @(posedge clk);
        for (int i = 0; i < 8; i++) drive_bit(b[i], glitch_bit == i);
        drive_bit(stop_bit, 1'b0);
        g = (!stop_bit && gap < 2) ? 2 : gap;
        if (g > 0) begin
            @(posedge clk);
            #1 RxD = 1'b1;
            repeat (g - 1) @(posedge clk);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || ferr_pend != 0 || ovr_pend != 0) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        chk("drain_timeout", n < 3000, 1'b1);
        @(posedge clk);
        #1 RxD = 1'b1;
        repeat (CPB + 4) @(posedge clk);
        #1 chk("busy_after_drain", busy, 1'b0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rx_data"}, rx_data, 8'h00);
        chk({tag, "_rx_valid"}, rx_valid, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_frame_err"}, frame_err, 1'b0);
        chk({tag, "_overrun"}, overrun, 1'b0);
    endtask

    initial begin
        logic [7:0] b;
        logic       sb;
        int         gap;

        reset = 1'b1;
        RxD = 1'b1;
        rx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk_reset_outputs("reset");
        reset = 1'b0;
        repeat (5) @(posedge clk);

        send_frame(8'hA5, 1'b1, 4, -1);
        wait_drain();

        send_frame(8'h3C, 1'b0, 4, -1);
        send_frame(8'h81, 1'b1, 0, -1);
        wait_drain();

        for (int i = 0; i < 20; i++) begin
            b = 8'($urandom_range(0, 255));
            sb = ($urandom_range(0, 4) != 0);
            gap = $urandom_range(0, 2 * CPB);
            send_frame(b, sb, gap, -1);
        end
        wait_drain();

        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom_range(0, 255));
            send_frame(b, 1'b1, 0, -1);
        end
        wait_drain();

        // Held byte with a second frame arriving behind it.
        @(posedge clk);
        #1 rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, 0, -1);
        send_frame(8'h22, 1'b1, 4, -1);
        repeat (20) @(posedge clk);
        #1;
        chk("held_rx_valid", rx_valid, 1'b1);
        chk("held_rx_data", rx_data, 8'h11);
        chk("overrun_seen", ovr_pend, 0);
        rx_ready = 1'b1;
        model_held = 1'b0;
        @(posedge clk);
        #1 chk("valid_clears_on_ready", rx_valid, 1'b0);
        wait_drain();

        // Four-cycle low pulse: start is detected, then rejected at mid start bit.
        @(posedge clk);
        #1 RxD = 1'b0;
        repeat (4) @(posedge clk);
        #1 RxD = 1'b1;
        chk("false_start_busy_high", busy, 1'b1);
        repeat (3 * CPB) @(posedge clk);
        #1 chk("false_start_busy_low", busy, 1'b0);
        chk("false_start_no_valid", rx_valid, 1'b0);

`ifdef UART_RX_MAJORITY_EN
        send_frame(8'hFF, 1'b1, 4, 3);
        wait_drain();
`endif

        // Reset during data bit 3 of a frame.
        b = 8'h96;
        @(posedge clk);
        #1 RxD = 1'b0;
        repeat (CPB - 1) @(posedge clk);
        for (int i = 0; i < 3; i++) drive_bit(b[i], 1'b0);
        @(posedge clk);
        #1 RxD = b[3];
        repeat (HALF) @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk_reset_outputs("midframe_reset");
        RxD = 1'b1;
        reset = 1'b0;
        repeat (3 * CPB) @(posedge clk);
        #1 chk("post_reset_idle", busy, 1'b0);
        send_frame(8'h5A, 1'b1, 4, -1);
        wait_drain();

        // Line held low through reset release must not start a frame.
        @(posedge clk);
        #1 reset = 1'b1;
        RxD = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2 * CPB) @(posedge clk);
        #1 chk("low_line_no_start", busy, 1'b0);
        RxD = 1'b1;
        repeat (5) @(posedge clk);
        send_frame(8'hC3, 1'b1, 4, -1);
        wait_drain();

        chk("exp_queue_empty", exp_q.size(), 0);
        chk("ferr_pending_zero", ferr_pend, 0);
        chk("ovr_pending_zero", ovr_pend, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10416, meaning clk cycles per bit (100 MHz / 9600 baud); legal range 8..65535.
REQ-002 SHALL have port clk  input  1  rising-edge clock, 100 MHz.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port RxD  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-005 SHALL have port rx_ready  input  1  consumer accepts rx_data when rx_valid is high.
REQ-006 SHALL have port rx_data  output  8  received byte.
REQ-007 SHALL have port rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-008 SHALL have port busy  output  1  high whenever the FSM is not IDLE.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 SHALL have port overrun  output  1  one-cycle pulse: byte completed while the previous byte was still held and not accepted.

Function
REQ-011 SHALL pass RxD through a 2-flop synchroniser (both flops reset to 1) to produce rxd_s; all decisions use rxd_s only.
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP, using one bit-period counter (width ceil(log2(CLKS_PER_BIT))) and a 3-bit bit index.
REQ-013 IDLE: on an rxd_s falling edge (previous 1, current 0), go to START and clear the counter; a line held low SHALL NOT retrigger.
REQ-014 START: when counter == CLKS_PER_BIT/2-1 (integer division), sample the line. If 0, go to DATA with counter and bit index cleared. If 1 (false start/glitch), go to IDLE with no output activity.
REQ-015 DATA: when counter == CLKS_PER_BIT-1, sample, shift into bit[index] (LSB first) and clear the counter. After index 7, go to STOP; otherwise increment the index.
REQ-016 STOP: when counter == CLKS_PER_BIT-1, sample and go to IDLE. Sample 1 = byte complete. Sample 0 = pulse frame_err for 1 cycle; rx_data and rx_valid unchanged.
REQ-017 On byte complete with rx_valid=0, or with rx_valid=1 and rx_ready=1 on the same edge: rx_data <= new byte and rx_valid <= 1 on the next edge.
REQ-018 On byte complete with rx_valid=1 and rx_ready=0: discard the new byte, retain rx_data, keep rx_valid=1, pulse overrun for 1 cycle.
REQ-019 Without byte complete, rx_valid SHALL clear on the edge where rx_valid=1 and rx_ready=1; rx_ready while rx_valid=0 has no effect.
REQ-020 rx_data SHALL be stable while rx_valid=1 and SHALL update only per REQ-017.
REQ-021 Latency: rx_valid SHALL rise exactly 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles after the first clk edge that registers RxD low (±0; 3 with the REQ-026 filter unchanged).
REQ-022 A new start edge SHALL be accepted in the cycle after STOP returns to IDLE, so back-to-back frames with no idle gap are received.

Reset
REQ-023 While reset is high at a clk edge, the FSM, counter and index SHALL clear and the synchroniser SHALL load 1. Outputs SHALL reset to: rx_data=8'h00, rx_valid=0, busy=0, frame_err=0, overrun=0.
REQ-024 Reset mid-frame SHALL abandon the frame with no valid, frame_err or overrun pulse. After release, a still-low line SHALL NOT start a frame until it has been seen high.

Configuration
REQ-025 Macro UART_RX_MAJORITY_EN SHALL select the sampling mode.
REQ-026 Defined: each sample in REQ-014/015/016 SHALL be the 2-of-3 majority of rxd_s at the sample cycle and the two preceding cycles. A single-cycle glitch SHALL NOT corrupt a bit.
REQ-027 Undefined: each sample SHALL be rxd_s at the sample cycle only. Ports and latency SHALL be identical in both modes.

Verification
REQ-028 CLKS_PER_BIT=16, send 0xA5 8N1, rx_ready=1 -> rx_valid high 1 cycle, rx_data=0xA5, no frame_err or overrun, busy low after.
REQ-029 CLKS_PER_BIT=16, send 0x3C with stop bit 0 -> one frame_err pulse, rx_valid stays 0, the next 0x81 frame is received correctly.
REQ-030 rx_ready=0, send 0x11 then 0x22 -> rx_data=0x11 held, one overrun pulse at the 0x22 stop, raise rx_ready -> rx_valid clears next edge.
REQ-031 RxD low pulse of 4 cycles (CLKS_PER_BIT=16) -> false start, returns to IDLE, no outputs. With UART_RX_MAJORITY_EN, a 1-cycle glitch mid-bit in 0xFF -> rx_data=0xFF.
REQ-032 Assert reset during bit 3 of a frame -> all outputs at reset values, no pulses. Next full frame 0x5A -> rx_data=0x5A.
REQ-033 CLKS_PER_BIT=10416, loop back from the team's Transmitter sending 0x41 -> rx_data=0x41 at the REQ-021 latency.
